// File: rtl/evm_result_reader.sv
// Reads the EVM core's results once voting closes: steps through the three counts and the
// winner view, captures each tuple and sends it out as a fixed UART-style frame on tx.
module evm_result_reader #(
   parameter int WIDTH   = 7,
   parameter int SETTLE  = 2,
   parameter int BIT_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             voting_done,
   input  logic             invalid_results,
   input  logic [1:0]       candidate_name,
   input  logic [WIDTH-1:0] results,
   output logic [1:0]       display_results,
   output logic             display_winner,
   output logic             tx,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam int FRAME_W = WIDTH + 5;
   localparam int SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int DIV_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int BIT_W   = $clog2(FRAME_W);

   // The zero-cycle NEXT decision is taken inside the last SHIFT cycle.
   typedef enum logic [1:0] {IDLE, SELECT, SHIFT, FINISH} state_t;

   state_t             state_q, state_d;
   logic [1:0]         k_q, k_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [1:0]         dres_d;
   logic               dwin_d, busy_d, done_d, error_d;

   // The frame register doubles as the tx flop: its MSB is the bit on the line.
   assign tx = frame_q[FRAME_W-1];

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      settle_d = settle_q;
      div_d    = div_q;
      bit_d    = bit_q;
      frame_d  = frame_q;
      dres_d   = display_results;
      dwin_d   = display_winner;
      busy_d   = busy;
      done_d   = 1'b0;
      error_d  = error;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (!voting_done) begin
                  error_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  error_d  = 1'b0;
                  k_d      = 2'd0;
                  settle_d = '0;
                  busy_d   = 1'b1;
                  dres_d   = 2'b00;
                  dwin_d   = 1'b0;
                  state_d  = SELECT;
               end
            end
         end

         SELECT: begin
            if (settle_q == SET_W'(SETTLE - 1)) begin
               frame_d = {1'b0, candidate_name, results, invalid_results, 1'b1};
               div_d   = '0;
               bit_d   = '0;
               state_d = SHIFT;
               if (invalid_results) error_d = 1'b1;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end

         SHIFT: begin
            if (div_q != DIV_W'(BIT_DIV - 1)) begin
               div_d = div_q + DIV_W'(1);
            end else begin
               div_d = '0;
               if (bit_q != BIT_W'(FRAME_W - 1)) begin
                  bit_d   = bit_q + BIT_W'(1);
                  frame_d = {frame_q[FRAME_W-2:0], 1'b1};
               end else begin
                  frame_d = '1;
                  if (k_q != 2'd3) begin
                     k_d      = k_q + 2'd1;
                     settle_d = '0;
                     dres_d   = (k_q == 2'd2) ? 2'b00 : k_q + 2'd1;
                     dwin_d   = (k_q == 2'd2);
                     state_d  = SELECT;
                  end else begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     dres_d  = 2'b00;
                     dwin_d  = 1'b0;
                     state_d = FINISH;
                  end
               end
            end
         end

         FINISH: state_d = IDLE;

         default: state_d = IDLE;
      endcase

      // Losing voting_done mid-readout abandons whatever frame was in flight.
      if ((state_q == SELECT || state_q == SHIFT) && !voting_done) begin
         frame_d = '1;
         busy_d  = 1'b0;
         dres_d  = 2'b00;
         dwin_d  = 1'b0;
         error_d = 1'b1;
         done_d  = 1'b1;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         k_q             <= 2'd0;
         settle_q        <= '0;
         div_q           <= '0;
         bit_q           <= '0;
         frame_q         <= '1;
         display_results <= 2'b00;
         display_winner  <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
      end else begin
         state_q         <= state_d;
         k_q             <= k_d;
         settle_q        <= settle_d;
         div_q           <= div_d;
         bit_q           <= bit_d;
         frame_q         <= frame_d;
         display_results <= dres_d;
         display_winner  <= dwin_d;
         busy            <= busy_d;
         done            <= done_d;
         error           <= error_d;
      end
   end

endmodule

// File: tb/tb_evm_result_reader.sv
// Bench for evm_result_reader: a behavioural EVM core answers the selects, serial monitors
// decode tx frames and pop expected frames queued by the stimulus.
module tb_evm_result_reader;

   logic clk = 1'b0;
   logic rst, start, start_f, voting_done, tie;
   logic [6:0] cnt1, cnt2, cnt3;

   logic [1:0] dres, dres_f, name_a, name_b;
   logic       dwin, dwin_f, tx, tx_f, busy, busy_f, done, done_f, error, error_f;
   logic       inv_a, inv_b;
   logic [6:0] res_a, res_b;

   int checks = 0;
   int failures = 0;
   int rel = 0;
   logic [11:0] exp_a[$];
   logic [11:0] exp_b[$];

   localparam logic [11:0] F521_0 = 12'b0_01_0000101_0_1;
   localparam logic [11:0] F521_1 = 12'b0_10_0000010_0_1;
   localparam logic [11:0] F521_2 = 12'b0_11_0000001_0_1;
   localparam logic [11:0] F521_3 = 12'b0_01_0000101_0_1;
   localparam logic [11:0] F_TIE  = 12'b0_00_0000000_1_1;

   always #5 clk = ~clk;

   // Behavioural core: count view selects candidate sel+1, winner view reports the maximum.
   function automatic logic [9:0] coreResp(input logic [1:0] sel, input logic win,
                                           input logic vd, input logic tie_in,
                                           input logic [6:0] a, input logic [6:0] b,
                                           input logic [6:0] c);
      logic [9:0] r;
      r = '0;
      if (vd && tie_in) r = {1'b1, 2'b00, 7'd0};
      else if (vd && win) begin
         if (a >= b && a >= c) r = {1'b0, 2'b01, a};
         else if (b >= c)      r = {1'b0, 2'b10, b};
         else                  r = {1'b0, 2'b11, c};
      end else if (vd) begin
         case (sel)
            2'b00:   r = {1'b0, 2'b01, a};
            2'b01:   r = {1'b0, 2'b10, b};
            2'b10:   r = {1'b0, 2'b11, c};
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   assign {inv_a, name_a, res_a} = coreResp(dres, dwin, voting_done, tie, cnt1, cnt2, cnt3);
   assign {inv_b, name_b, res_b} = coreResp(dres_f, dwin_f, voting_done, tie, cnt1, cnt2, cnt3);

   evm_result_reader dut (
      .clk(clk), .rst(rst), .start(start), .voting_done(voting_done),
      .invalid_results(inv_a), .candidate_name(name_a), .results(res_a),
      .display_results(dres), .display_winner(dwin), .tx(tx),
      .busy(busy), .done(done), .error(error)
   );

   evm_result_reader #(.WIDTH(7), .SETTLE(1), .BIT_DIV(1)) dut_f (
      .clk(clk), .rst(rst), .start(start_f), .voting_done(voting_done),
      .invalid_results(inv_b), .candidate_name(name_b), .results(res_b),
      .display_results(dres_f), .display_winner(dwin_f), .tx(tx_f),
      .busy(busy_f), .done(done_f), .error(error_f)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goTo(input int n);
      while (rel < n) begin
         step();
         rel++;
      end
   endtask

   task automatic applyStimulus(input logic vd, input logic tie_in, input logic [6:0] a,
                                input logic [6:0] b, input logic [6:0] c);
      voting_done = vd;
      tie = tie_in;
      cnt1 = a;
      cnt2 = b;
      cnt3 = c;
      start = 1'b1;
      step();
      start = 1'b0;
      rel = 1;
   endtask

   // Monitor for the default instance: a frame starts on a falling tx edge while busy.
   initial begin : mon_a
      logic [11:0] bits;
      logic ok, prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && busy && prev && !tx) begin
            bits[11] = tx;
            ok = 1'b1;
            for (int i = 10; i >= 0; i--) begin
               repeat (4) @(negedge clk);
               if (rst || !busy) ok = 1'b0;
               bits[i] = tx;
            end
            if (ok) begin
               if (exp_a.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL frame_a unexpected actual=%b expected=none", bits);
               end else begin
                  checkOutput("frame_a", 32'(bits), 32'(exp_a.pop_front()));
               end
            end
         end
         prev = tx;
      end
   end

   initial begin : mon_b
      logic [11:0] bits;
      logic ok, prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && busy_f && prev && !tx_f) begin
            bits[11] = tx_f;
            ok = 1'b1;
            for (int i = 10; i >= 0; i--) begin
               @(negedge clk);
               if (rst || !busy_f) ok = 1'b0;
               bits[i] = tx_f;
            end
            if (ok) begin
               if (exp_b.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL frame_b unexpected actual=%b expected=none", bits);
               end else begin
                  checkOutput("frame_b", 32'(bits), 32'(exp_b.pop_front()));
               end
            end
         end
         prev = tx_f;
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; start_f = 1'b0; voting_done = 1'b0; tie = 1'b0;
      cnt1 = '0; cnt2 = '0; cnt3 = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
      checkOutput("reset_tx", tx, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_error", error, 0);
      checkOutput("reset_dres", dres, 0);
      checkOutput("reset_dwin", dwin, 0);

      $display("[TB] normal readout 5/2/1");
      exp_a.push_back(F521_0); exp_a.push_back(F521_1);
      exp_a.push_back(F521_2); exp_a.push_back(F521_3);
      applyStimulus(1'b1, 1'b0, 7'd5, 7'd2, 7'd1);
      checkOutput("norm_busy_t1", busy, 1);
      checkOutput("norm_dres_t1", dres, 0);
      checkOutput("norm_dwin_t1", dwin, 0);
      goTo(2);
      checkOutput("norm_tx_settle", tx, 1);
      goTo(3);
      checkOutput("norm_startbit", tx, 0);
      goTo(52);
      checkOutput("norm_dres_k1", dres, 2'b01);
      goTo(60);
      start = 1'b1;
      goTo(61);
      start = 1'b0;
      goTo(152);
      checkOutput("norm_dres_k3", dres, 0);
      checkOutput("norm_dwin_k3", dwin, 1);
      goTo(200);
      checkOutput("norm_done_t200", done, 0);
      checkOutput("norm_busy_t200", busy, 1);
      goTo(201);
      checkOutput("norm_done_t201", done, 1);
      checkOutput("norm_busy_t201", busy, 0);
      checkOutput("norm_error", error, 0);
      checkOutput("norm_dwin_end", dwin, 0);
      goTo(202);
      checkOutput("norm_done_pulse", done, 0);

      $display("[TB] refused start");
      applyStimulus(1'b0, 1'b0, 7'd5, 7'd2, 7'd1);
      checkOutput("ref_done", done, 1);
      checkOutput("ref_error", error, 1);
      checkOutput("ref_busy", busy, 0);
      checkOutput("ref_tx", tx, 1);
      checkOutput("ref_dres", dres, 0);
      goTo(2);
      checkOutput("ref_done_pulse", done, 0);
      checkOutput("ref_busy_t2", busy, 0);

      $display("[TB] tie readout 3/3/1");
      repeat (4) exp_a.push_back(F_TIE);
      applyStimulus(1'b1, 1'b1, 7'd3, 7'd3, 7'd1);
      checkOutput("tie_error_cleared", error, 0);
      goTo(3);
      checkOutput("tie_error_set", error, 1);
      goTo(201);
      checkOutput("tie_done", done, 1);
      checkOutput("tie_error_end", error, 1);

      $display("[TB] abort during frame 2");
      repeat (5) step();
      exp_a.push_back(F521_0); exp_a.push_back(F521_1);
      applyStimulus(1'b1, 1'b0, 7'd5, 7'd2, 7'd1);
      checkOutput("abort_error_cleared", error, 0);
      goTo(119);
      checkOutput("abort_busy_pre", busy, 1);
      checkOutput("abort_dres_pre", dres, 2'b10);
      goTo(120);
      voting_done = 1'b0;
      goTo(121);
      checkOutput("abort_tx", tx, 1);
      checkOutput("abort_done", done, 1);
      checkOutput("abort_error", error, 1);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_dres", dres, 0);
      goTo(122);
      checkOutput("abort_done_pulse", done, 0);
      repeat (60) step();
      exp_a.push_back(F521_0); exp_a.push_back(F521_1);
      exp_a.push_back(F521_2); exp_a.push_back(F521_3);
      applyStimulus(1'b1, 1'b0, 7'd5, 7'd2, 7'd1);
      checkOutput("rerun_error_cleared", error, 0);
      goTo(200);
      checkOutput("rerun_busy_t200", busy, 1);
      goTo(201);
      checkOutput("rerun_done", done, 1);
      checkOutput("rerun_error", error, 0);

      $display("[TB] reset during shift");
      repeat (5) step();
      applyStimulus(1'b1, 1'b1, 7'd3, 7'd3, 7'd1);
      goTo(3);
      checkOutput("rst_pre_tx", tx, 0);
      checkOutput("rst_pre_error", error, 1);
      rst = 1'b1;
      goTo(4);
      checkOutput("rst_tx", tx, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_error", error, 0);
      checkOutput("rst_dres", dres, 0);
      checkOutput("rst_dwin", dwin, 0);
      rst = 1'b0;
      repeat (5) step();

      $display("[TB] fast instance 9/20/3");
      voting_done = 1'b1; tie = 1'b0;
      cnt1 = 7'd9; cnt2 = 7'd20; cnt3 = 7'd3;
      exp_b.push_back(12'b0_01_0001001_0_1);
      exp_b.push_back(12'b0_10_0010100_0_1);
      exp_b.push_back(12'b0_11_0000011_0_1);
      exp_b.push_back(12'b0_10_0010100_0_1);
      start_f = 1'b1;
      step();
      start_f = 1'b0;
      rel = 1;
      checkOutput("fast_busy_t1", busy_f, 1);
      checkOutput("fast_tx_t1", tx_f, 1);
      goTo(2);
      checkOutput("fast_startbit", tx_f, 0);
      goTo(14);
      checkOutput("fast_dres_k1", dres_f, 2'b01);
      goTo(30);
      start_f = 1'b1;
      goTo(31);
      start_f = 1'b0;
      goTo(52);
      checkOutput("fast_done_t52", done_f, 0);
      checkOutput("fast_busy_t52", busy_f, 1);
      goTo(53);
      checkOutput("fast_done_t53", done_f, 1);
      checkOutput("fast_busy_t53", busy_f, 0);
      checkOutput("fast_error", error_f, 0);

      repeat (20) step();
      checkOutput("exp_a_drained", exp_a.size(), 0);
      checkOutput("exp_b_drained", exp_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
